// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary operand store: trit encoding,
// the trit type and a width helper that never returns zero.
package ternary_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t TRIT_ZERO    = 2'b00;
  localparam trit_t TRIT_POS     = 2'b01;
  localparam trit_t TRIT_NEG     = 2'b10;
  localparam trit_t TRIT_ILLEGAL = 2'b11;

  // Index width for n items, at least one bit so single-item vectors stay legal.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ternary_rr_arbiter.sv
// Round-robin arbiter for one bank: grants the first requester at or after
// the pointer, wrapping around. Purely combinational; the pointer is owned
// by the caller.
import ternary_pkg::*;

module ternary_rr_arbiter #(
  parameter int  NUM_PORTS = 2,
  localparam int PW        = clog2_min1(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [PW-1:0]        i_ptr,
  output logic [NUM_PORTS-1:0] o_grant
);

  logic [2*NUM_PORTS-1:0] w_req2;
  logic [2*NUM_PORTS-1:0] w_gnt2;
  logic [NUM_PORTS-1:0]   w_rot;

  // Rotate requests so the pointer lands on bit 0, pick the lowest set bit,
  // then rotate the one-hot grant back into port order.
  always_comb begin
    w_req2 = {i_req, i_req} >> i_ptr;
    w_rot  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (w_req2[i]) begin
        w_rot    = '0;
        w_rot[i] = 1'b1;
      end
    end
    w_gnt2  = {w_rot, w_rot} << i_ptr;
    o_grant = w_gnt2[2*NUM_PORTS-1:NUM_PORTS];
  end

endmodule

// File: rtl/ternary_sram_banked.sv
// Multi-port, address-interleaved ternary operand store.
// Bank = low address bits, row = remaining bits. Each bank has its own
// round-robin arbiter; reads return two cycles after acceptance on the
// accepting port. Optional build macro TERNARY_SRAM_TRIT_CHECK_EN scrubs
// illegal trits on write and raises a sticky trit_err flag.
import ternary_pkg::*;

module ternary_sram_banked #(
  parameter int  NUM_PORTS  = 2,
  parameter int  NUM_BANKS  = 4,
  parameter int  ADDR_WIDTH = 12,
  parameter int  TRITS      = 12,
  localparam int DATA_WIDTH = 2 * TRITS
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  rsp_rdata,
  output logic [15:0]                      stall_cnt,
  output logic                             trit_err
);

  localparam int PW    = clog2_min1(NUM_PORTS);
  localparam int BW    = clog2_min1(NUM_BANKS);
  localparam int LOG2B = $clog2(NUM_BANKS);
  localparam int ROW_W = ADDR_WIDTH - LOG2B;
  localparam int DEPTH = 1 << ROW_W;

  // Replace every illegal trit with zero.
  function automatic logic [DATA_WIDTH-1:0] trit_sanitize(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    r = d;
    for (int t = 0; t < TRITS; t++) begin
      if (trit_t'(d[2*t +: 2]) == TRIT_ILLEGAL) r[2*t +: 2] = TRIT_ZERO;
    end
    return r;
  endfunction

  // True when any trit of the word carries the illegal code.
  function automatic logic trit_has_illegal(input logic [DATA_WIDTH-1:0] d);
    logic r;
    r = 1'b0;
    for (int t = 0; t < TRITS; t++) begin
      if (trit_t'(d[2*t +: 2]) == TRIT_ILLEGAL) r = 1'b1;
    end
    return r;
  endfunction

  logic [NUM_PORTS-1:0][BW-1:0]         w_port_bank;
  logic [NUM_PORTS-1:0][ROW_W-1:0]      w_port_row;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] w_port_wdata;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0]  w_grant_all;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] w_bank_rdata;

  logic [NUM_PORTS-1:0]                 r_vld_p1;
  logic [NUM_PORTS-1:0][BW-1:0]         r_bank_p1;
  logic [NUM_PORTS-1:0]                 r_rsp_vld_p2;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] r_rsp_rdata_p2;
  logic [15:0]                          r_stall_cnt;
  logic                                 w_stall;

`ifdef TERNARY_SRAM_TRIT_CHECK_EN
  logic [NUM_PORTS-1:0] w_port_bad;
  logic                 w_wr_bad;
  logic                 r_trit_err;
`endif

  // Per-port address split and write-data conditioning.
  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_raw;
    assign w_addr           = req_addr[gp*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_raw            = req_wdata[gp*DATA_WIDTH +: DATA_WIDTH];
    assign w_port_bank[gp]  = BW'(w_addr % ADDR_WIDTH'(NUM_BANKS));
    assign w_port_row[gp]   = ROW_W'(w_addr >> LOG2B);
`ifdef TERNARY_SRAM_TRIT_CHECK_EN
    assign w_port_wdata[gp] = trit_sanitize(w_raw);
    assign w_port_bad[gp]   = trit_has_illegal(w_raw);
`else
    assign w_port_wdata[gp] = w_raw;
`endif
  end

  // ---- stage p0: arbitration and bank array access ----
  for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
    logic [NUM_PORTS-1:0]  w_req;
    logic [NUM_PORTS-1:0]  w_grant;
    logic [PW-1:0]         r_rr;
    logic [PW-1:0]         w_rr_nxt;
    logic                  w_we;
    logic                  w_re;
    logic [ROW_W-1:0]      w_row;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata_p1;

    // Requests aimed at this bank; nothing is granted while in reset.
    always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        w_req[p] = rst_n & req_valid[p] & (w_port_bank[p] == BW'(gb));
      end
    end

    ternary_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
      .i_req   (w_req),
      .i_ptr   (r_rr),
      .o_grant (w_grant)
    );

    // Steer the granted port's operation onto the bank and compute the next pointer.
    always_comb begin
      w_we     = 1'b0;
      w_re     = 1'b0;
      w_row    = '0;
      w_wdata  = '0;
      w_rr_nxt = r_rr;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_grant[p]) begin
          w_we     = req_we[p];
          w_re     = ~req_we[p];
          w_row    = w_port_row[p];
          w_wdata  = w_port_wdata[p];
          w_rr_nxt = PW'((p + 1) % NUM_PORTS);
        end
      end
    end

    // Round-robin pointer advances only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_rr <= '0;
      else if (|w_grant) r_rr <= w_rr_nxt;
    end

    // Bank array: single operation per cycle, contents never reset.
    always_ff @(posedge clk) begin
      if (w_we) r_mem[w_row] <= w_wdata;
      if (w_re) r_rdata_p1   <= r_mem[w_row];
    end

    assign w_grant_all[gb]  = w_grant;
    assign w_bank_rdata[gb] = r_rdata_p1;
  end

  // A port is ready when any bank granted it.
  always_comb begin
    req_ready = '0;
    for (int b = 0; b < NUM_BANKS; b++) req_ready = req_ready | w_grant_all[b];
  end

  // ---- stage p1: remember which bank each accepted read used ----
  always_ff @(posedge clk) begin
    r_bank_p1 <= w_port_bank;
  end

  // ---- stage p2: route bank read data to the requesting port ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1       <= '0;
      r_rsp_vld_p2   <= '0;
      r_rsp_rdata_p2 <= '0;
    end else begin
      r_vld_p1     <= req_ready & ~req_we;
      r_rsp_vld_p2 <= r_vld_p1;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (r_vld_p1[p]) r_rsp_rdata_p2[p] <= w_bank_rdata[r_bank_p1[p]];
      end
    end
  end

  assign rsp_valid = r_rsp_vld_p2;
  assign rsp_rdata = r_rsp_rdata_p2;

  assign w_stall = |(req_valid & ~req_ready);

  // Saturating count of cycles where some port waited.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_stall_cnt <= '0;
    else if (w_stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;

`ifdef TERNARY_SRAM_TRIT_CHECK_EN
  assign w_wr_bad = |(req_ready & req_we & w_port_bad);

  // Sticky flag for any accepted write that carried an illegal trit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_trit_err <= 1'b0;
    else if (w_wr_bad) r_trit_err <= 1'b1;
  end

  assign trit_err = r_trit_err;
`else
  assign trit_err = 1'b0;
`endif

endmodule

// File: tb/tb_ternary_sram_banked.sv
// Self-checking bench for ternary_sram_banked (2 ports, 4 banks, 12-bit
// address, 12 trits). A behavioural model (address-keyed memory, per-bank
// priority pointers, expected-response delay line) is compared against the
// DUT on every falling edge; directed sequences add literal expectations.
module tb_ternary_sram_banked;

  localparam int NP = 2;
  localparam int NB = 4;
  localparam int AW = 12;
  localparam int TR = 12;
  localparam int DW = 2 * TR;

`ifdef TERNARY_SRAM_TRIT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP-1:0]     req_valid = '0;
  logic [NP-1:0]     req_ready;
  logic [NP-1:0]     req_we = '0;
  logic [NP*AW-1:0]  req_addr = '0;
  logic [NP*DW-1:0]  req_wdata = '0;
  logic [NP-1:0]     rsp_valid;
  logic [NP*DW-1:0]  rsp_rdata;
  logic [15:0]       stall_cnt;
  logic              trit_err;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  ternary_sram_banked #(
    .NUM_PORTS(NP), .NUM_BANKS(NB), .ADDR_WIDTH(AW), .TRITS(TR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .stall_cnt(stall_cnt), .trit_err(trit_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mmem [int];
  int            m_rr [NB];
  logic [15:0]   m_stall = '0;
  logic          m_err = 1'b0;
  logic [NP-1:0] e1_vld = '0, e2_vld = '0;
  logic [NP-1:0] e1_known = '0, e2_known = '0;
  logic [DW-1:0] e1_dat [NP];
  logic [DW-1:0] e2_dat [NP];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int port_addr(input int p);
    return int'(req_addr[p*AW +: AW]);
  endfunction

  // Which ports the spec's rotating-priority rule grants right now.
  function automatic logic [NP-1:0] model_grant();
    logic [NP-1:0] g;
    g = '0;
    if (rst_n) begin
      for (int b = 0; b < NB; b++) begin
        bit taken;
        taken = 1'b0;
        for (int k = 0; k < NP; k++) begin
          int p;
          p = (m_rr[b] + k) % NP;
          if (!taken && req_valid[p] && (port_addr(p) % NB) == b) begin
            g[p] = 1'b1;
            taken = 1'b1;
          end
        end
      end
    end
    return g;
  endfunction

  function automatic logic [DW-1:0] scrub(input logic [DW-1:0] d, output bit had_bad);
    logic [DW-1:0] r;
    r = d;
    had_bad = 1'b0;
    for (int t = 0; t < TR; t++) begin
      if (d[2*t +: 2] == 2'b11) begin
        had_bad = 1'b1;
        r[2*t +: 2] = 2'b00;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) m_rr[b] = 0;
    m_stall  = '0;
    m_err    = 1'b0;
    e1_vld   = '0;
    e2_vld   = '0;
    e1_known = '0;
    e2_known = '0;
  endtask

  // Model advances on every active edge, reset clears it asynchronously.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      logic [NP-1:0] g;
      g = model_grant();
      e2_vld   = e1_vld;
      e2_known = e1_known;
      for (int p = 0; p < NP; p++) e2_dat[p] = e1_dat[p];
      for (int p = 0; p < NP; p++) begin
        e1_vld[p]   = g[p] & ~req_we[p];
        e1_known[p] = 1'b0;
        if (g[p] && !req_we[p] && mmem.exists(port_addr(p))) begin
          e1_dat[p]   = mmem[port_addr(p)];
          e1_known[p] = 1'b1;
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (g[p] && req_we[p]) begin
          bit hb;
          logic [DW-1:0] d;
          d = scrub(req_wdata[p*DW +: DW], hb);
          if (CHK) begin
            mmem[port_addr(p)] = d;
            if (hb) m_err = 1'b1;
          end else begin
            mmem[port_addr(p)] = req_wdata[p*DW +: DW];
          end
          m_rr[port_addr(p) % NB] = (p + 1) % NP;
        end else if (g[p]) begin
          m_rr[port_addr(p) % NB] = (p + 1) % NP;
        end
      end
      if (|(req_valid & ~g) && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    end
  end

  // Compare process: DUT against model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req_ready", 64'(req_ready), 64'(model_grant()));
      for (int p = 0; p < NP; p++) begin
        chk("rsp_valid", 64'(rsp_valid[p]), 64'(e2_vld[p]));
        if (e2_vld[p] && e2_known[p])
          chk("rsp_rdata", 64'(rsp_rdata[p*DW +: DW]), 64'(e2_dat[p]));
      end
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("trit_err", 64'(trit_err), 64'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_port(input int p, input bit v, input bit we, input int a, input logic [DW-1:0] d);
    req_valid[p]          = v;
    req_we[p]             = we;
    req_addr[p*AW +: AW]  = AW'(a);
    req_wdata[p*DW +: DW] = d;
  endtask

  task automatic idle_all();
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] legal_word();
    logic [DW-1:0] d;
    for (int t = 0; t < TR; t++) d[2*t +: 2] = 2'($urandom_range(0, 2));
    return d;
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] exp_d;
    logic [NP-1:0] acc;
    model_reset();

    // Reset state, with requests already presented.
    set_port(0, 1'b1, 1'b0, 1, '0);
    set_port(1, 1'b1, 1'b0, 5, '0);
    cmp_en = 1'b1;
    step();
    step();
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_stall", 64'(stall_cnt), 64'(0));
    chk("rst_trit_err", 64'(trit_err), 64'(0));
    idle_all();
    rst_n = 1'b1;
    step();

    // Fill addresses 0..31 through port 1 (leaves every pointer at 0).
    for (int a = 0; a < 32; a++) begin
      set_port(1, 1'b1, 1'b1, a, legal_word());
      step();
    end
    idle_all();
    step();

    // Write then read-back with two-cycle latency.
    set_port(0, 1'b1, 1'b1, 'h004, 24'h155555);
    step();
    set_port(0, 1'b1, 1'b0, 'h004, '0);
    step();
    idle_all();
    #1 chk("t1_early_valid", 64'(rsp_valid[0]), 64'(0));
    step();
    chk("t1_rsp_valid", 64'(rsp_valid[0]), 64'(1));
    chk("t1_rsp_rdata", 64'(rsp_rdata[DW-1:0]), 64'(24'h155555));

    // Two ports fight for bank 1: grants alternate starting with port 0.
    set_port(0, 1'b1, 1'b0, 'h001, '0);
    set_port(1, 1'b1, 1'b0, 'h005, '0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("t2_ready", 64'(req_ready), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      step();
    end
    idle_all();
    chk("t2_stall", 64'(stall_cnt), 64'(4));

    // Different banks never stall each other.
    set_port(0, 1'b1, 1'b0, 'h000, '0);
    set_port(1, 1'b1, 1'b0, 'h002, '0);
    for (int i = 0; i < 8; i++) begin
      #1 chk("t3_ready", 64'(req_ready), 64'(2'b11));
      step();
    end
    idle_all();
    chk("t3_stall", 64'(stall_cnt), 64'(4));
    step();
    step();

    // Illegal-trit write.
    exp_d = CHK ? 24'h000000 : 24'hC00003;
    set_port(0, 1'b1, 1'b1, 'h010, 24'hC00003);
    #1 chk("t4_err_before", 64'(trit_err), 64'(0));
    step();
    set_port(0, 1'b1, 1'b0, 'h010, '0);
    chk("t4_err_after", 64'(trit_err), 64'(CHK));
    step();
    idle_all();
    step();
    chk("t4_rsp_valid", 64'(rsp_valid[0]), 64'(1));
    chk("t4_rsp_rdata", 64'(rsp_rdata[DW-1:0]), 64'(exp_d));
    chk("t4_err_held", 64'(trit_err), 64'(CHK));

    // Reset while two reads are in flight.
    set_port(0, 1'b1, 1'b0, 'h000, '0);
    step();
    step();
    rst_n = 1'b0;
    set_port(0, 1'b1, 1'b0, 'h001, '0);
    set_port(1, 1'b1, 1'b0, 'h005, '0);
    #1;
    chk("t5_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("t5_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("t5_stall", 64'(stall_cnt), 64'(0));
    chk("t5_err", 64'(trit_err), 64'(0));
    chk("t5_ready_in_rst", 64'(req_ready), 64'(0));
    step();
    chk("t5_no_late_rsp", 64'(rsp_valid), 64'(0));
    rst_n = 1'b1;
    #1 chk("t5_port0_first", 64'(req_ready), 64'(2'b01));
    step();
    idle_all();
    step();

    // Randomized traffic; an ungranted request is held stable.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = model_grant();
      step();
      for (int p = 0; p < NP; p++) begin
        if (!req_valid[p] || acc[p]) begin
          set_port(p, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
                   int'($urandom_range(0, 31)), DW'($urandom));
        end
      end
    end
    @(negedge clk);
    step();
    idle_all();
    step();
    step();

    // Persistent conflict drives the stall counter into saturation.
    set_port(0, 1'b1, 1'b0, 'h001, '0);
    set_port(1, 1'b1, 1'b0, 'h005, '0);
    repeat (70000) @(posedge clk);
    #1 chk("t6_stall_sat", 64'(stall_cnt), 64'(16'hFFFF));
    idle_all();
    step();
    step();
    step();
    cmp_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
